fifo_flags_ctrl: RTL

//  Parametrised FIFO control unit: owns write/read pointers, fill count and all status flags.

---
 rtl/fifo_pkg.sv | 42 ++++
 rtl/d_ff_async_en.sv | 34 +++
 rtl/fifo_ptr_cnt.sv | 35 +++
 rtl/fifo_flags_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO flag/count control unit.
//   fifo_depth(addr_w)  : number of storage entries for a given address width
//   ptr_width(addr_w)   : pointer width (address plus one wrap bit)
//   count_width(addr_w) : occupancy width (must hold 0..DEPTH)
//   status_t            : packed non-watermark status flags held in one register
//   STATUS_RST          : reset value of status_t (empty asserted)
//   DEFAULT_* constants : default parameter values
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_ADDR_W    = 2;
  localparam int DEFAULT_AE_THRESH = 1;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

  // Default almost-full watermark sits one entry below full.
  function automatic int default_af_thresh(input int addr_w);
    return fifo_depth(addr_w) - 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic ovf;
    logic unf;
  } status_t;

  localparam status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, ovf: 1'b0, unf: 1'b0};

endpackage : fifo_pkg

// File: rtl/d_ff_async_en.sv
// -----------------------------------------------------------------------------
// d_ff_async_en
// Generic W-bit register with asynchronous active-low reset to RST_VAL and a
// load enable.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   en_i   : load enable
//   d_i    : next value
//   q_o    : registered value
// -----------------------------------------------------------------------------
module d_ff_async_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : d_ff_async_en

// File: rtl/fifo_ptr_cnt.sv
// -----------------------------------------------------------------------------
// fifo_ptr_cnt
// W-bit wrapping pointer counter. With W = ADDR_W+1 the MSB toggles each time
// the address part wraps, which lets full and empty be told apart.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (pointer -> 0)
//   inc_i  : advance the pointer by one this cycle
//   ptr_o  : current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr_cnt #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Natural W-bit overflow gives the modulo 2*DEPTH wrap.
  assign ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fifo_ptr_cnt

// File: rtl/fifo_flags_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_flags_ctrl
// FIFO control unit: owns the write/read pointers, the occupancy count and all
// status flags, and drives the storage array addresses and strobes.
//
// Optional feature macro: FIFO_FLAGS_WATERMARK_EN
//   defined     : registered almost_full (count >= AF_THRESH) and
//                 almost_empty (count <= AE_THRESH)
//   not defined : no watermark logic; almost_full = full, almost_empty = empty,
//                 AF_THRESH/AE_THRESH only range-checked
//
// Handshake: a request (w_en / r_en) is accepted in the same cycle it is
// presented unless the FIFO is full (write) or empty (read); w_ack / r_ack are
// the acceptance strobes and are purely combinational from registered flags.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   w_en, r_en          : write / read requests
//   clr_err             : clears sticky overflow/underflow (a new error wins)
//   w_ack, r_ack        : accepted write / read; storage strobes
//   w_addr, r_addr      : storage addresses (pointer without wrap bit)
//   count               : occupancy 0..DEPTH
//   full, empty         : count == DEPTH / count == 0
//   almost_full/_empty  : watermark flags
//   overflow, underflow : sticky error flags
// -----------------------------------------------------------------------------
module fifo_flags_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int AF_THRESH = default_af_thresh(ADDR_W),
  parameter int AE_THRESH = DEFAULT_AE_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic              r_en,
  input  logic              clr_err,
  output logic              w_ack,
  output logic              r_ack,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int PW    = ptr_width(ADDR_W);
  localparam int CW    = count_width(ADDR_W);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] count_t;

  localparam count_t DEPTH_C = count_t'(DEPTH);

  // Threshold legality is checked in every build so a bad configuration is
  // caught even while the watermark feature is compiled out.
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_af_range_err
    $error("fifo_flags_ctrl: AF_THRESH outside 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_ae_range_err
    $error("fifo_flags_ctrl: AE_THRESH outside 0..DEPTH-1");
  end

  ptr_t    w_ptr;
  ptr_t    r_ptr;
  count_t  count_q;
  count_t  count_d;
  status_t stat_q;
  status_t stat_d;

  // Acceptance only looks at registered flags, so there is no path from
  // w_en/r_en through the count adder back to the acks.
  assign w_ack = w_en & ~stat_q.full;
  assign r_ack = r_en & ~stat_q.empty;

  fifo_ptr_cnt #(.W(PW)) u_w_ptr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (w_ack),
    .ptr_o  (w_ptr)
  );

  fifo_ptr_cnt #(.W(PW)) u_r_ptr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (r_ack),
    .ptr_o  (r_ptr)
  );

  // Flags are computed from the next count so they are exact in the cycle
  // right after the access.
  always_comb begin
    count_d      = count_q + count_t'(w_ack) - count_t'(r_ack);
    stat_d       = STATUS_RST;
    stat_d.full  = (count_d == DEPTH_C);
    stat_d.empty = (count_d == '0);
    // Sticky errors: a new error in the same cycle as clr_err keeps the flag.
    stat_d.ovf   = (w_en & stat_q.full)  | (stat_q.ovf & ~clr_err);
    stat_d.unf   = (r_en & stat_q.empty) | (stat_q.unf & ~clr_err);
  end

  d_ff_async_en #(.W(CW), .RST_VAL('0)) u_count_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (1'b1),
    .d_i    (count_d),
    .q_o    (count_q)
  );

  d_ff_async_en #(.W($bits(status_t)), .RST_VAL(STATUS_RST)) u_status_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (1'b1),
    .d_i    (stat_d),
    .q_o    (stat_q)
  );

`ifdef FIFO_FLAGS_WATERMARK_EN
  localparam count_t AF_C = count_t'(AF_THRESH);
  localparam count_t AE_C = count_t'(AE_THRESH);

  // {almost_full, almost_empty}; reset state is empty, so almost_empty = 1.
  logic [1:0] wm_d;
  logic [1:0] wm_q;

  assign wm_d = {(count_d >= AF_C), (count_d <= AE_C)};

  d_ff_async_en #(.W(2), .RST_VAL(2'b01)) u_wm_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (1'b1),
    .d_i    (wm_d),
    .q_o    (wm_q)
  );

  assign almost_full  = wm_q[1];
  assign almost_empty = wm_q[0];
`else
  assign almost_full  = stat_q.full;
  assign almost_empty = stat_q.empty;
`endif

  assign w_addr    = w_ptr[ADDR_W-1:0];
  assign r_addr    = r_ptr[ADDR_W-1:0];
  assign count     = count_q;
  assign full      = stat_q.full;
  assign empty     = stat_q.empty;
  assign overflow  = stat_q.ovf;
  assign underflow = stat_q.unf;

  // Pointer/count consistency: the count register must always equal the
  // pointer distance, and full means same address with opposite wrap bits.
  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
    count_q == count_t'(w_ptr - r_ptr));
  a_full_matches_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
    stat_q.full == ((w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]) &&
                    (w_ptr[ADDR_W] != r_ptr[ADDR_W])));

endmodule : fifo_flags_ctrl
